m_seq_gen: RTL

Parametrised maximal-length (m-) sequence generator. It produces one PN chip per enabled clock from a Fibonacci LFSR whose degree, tap mask and default seed are parameters. It supports a runtime seed load and reports a period-start marker and chip phase. It feeds the BPSK spreading/modulation path, and replaces the fixed 4-stage generator.

---
 rtl/m_seq_gen.sv | 103 ++++++++++
 1 files changed

// File: rtl/m_seq_gen.sv
`default_nettype none
// ============================================================================
//  Module      : m_seq_gen
//  Description : Parametrised maximal-length (m-) sequence generator built on
//                a Fibonacci LFSR. It emits one PN chip per enabled clock and
//                reports a period-start marker (sop) and the chip phase. A
//                runtime seed can be loaded at any time; load beats enable.
//  Option      : M_SEQ_GEN_ZERO_GUARD_EN - when defined, a zero seed load is
//                replaced by SEED, and an all-zero state found at a step is
//                restarted from SEED with the phase re-anchored to 0, so the
//                generator can never lock up. When undefined, no guard logic
//                is built and the all-zero state emits constant 0 chips.
//  Revision    : 1.0 - initial release
// ============================================================================
module m_seq_gen #(
  parameter int unsigned      DEG  = 4,
  parameter logic [DEG-1:0]   TAPS = 4'b1001,
  parameter logic [DEG-1:0]   SEED = 4'b1000
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic           load,
  input  logic [DEG-1:0] seed_in,
  output logic           data_out,
  output logic           data_vld,
  output logic           sop,
  output logic [DEG-1:0] phase
);

  // Last chip index of a period (2^DEG-2), formed in 33 bits so DEG = 32
  // does not overflow before being cut back to DEG bits.
  localparam logic [32:0]    c_PMAX_W = (33'd1 << DEG) - 33'd2;
  localparam logic [DEG-1:0] c_PMAX   = c_PMAX_W[DEG-1:0];
  localparam logic [DEG-1:0] c_ONE    = {{(DEG-1){1'b0}}, 1'b1};

  logic [DEG-1:0] r_s;          // LFSR state; r_s[0] is the next chip
  logic [DEG-1:0] r_pcnt;       // index of the next chip within the period

  logic [DEG-1:0] w_load_val;   // value written into the LFSR on a load
  logic [DEG-1:0] w_cur_s;      // state the current step works from
  logic [DEG-1:0] w_cur_cnt;    // phase the current step works from
  logic           w_fb;
  logic [DEG-1:0] w_s_next;
  logic [DEG-1:0] w_pcnt_next;

`ifdef M_SEQ_GEN_ZERO_GUARD_EN
  logic w_s_zero;

  // A zero seed would lock the LFSR, so it is replaced by the default seed.
  assign w_load_val = (seed_in == '0) ? SEED : seed_in;

  // An all-zero state is treated as a fresh start from SEED at chip 0, so
  // this very step emits SEED[0] with sop and phase 0.
  assign w_s_zero  = (r_s == '0);
  assign w_cur_s   = w_s_zero ? SEED : r_s;
  assign w_cur_cnt = w_s_zero ? '0   : r_pcnt;
`else
  assign w_load_val = seed_in;
  assign w_cur_s    = r_s;
  assign w_cur_cnt  = r_pcnt;
`endif

  assign w_fb        = ^(w_cur_s & TAPS);
  assign w_s_next    = {w_fb, w_cur_s[DEG-1:1]};
  assign w_pcnt_next = (w_cur_cnt == c_PMAX) ? '0 : (w_cur_cnt + c_ONE);

  // LFSR state and phase counter: load re-anchors, enable steps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s    <= SEED;
      r_pcnt <= '0;
    end else if (load) begin
      r_s    <= w_load_val;
      r_pcnt <= '0;
    end else if (en) begin
      r_s    <= w_s_next;
      r_pcnt <= w_pcnt_next;
    end
  end

  // Registered chip outputs; data_out and phase hold whenever no step occurs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out <= 1'b0;
      data_vld <= 1'b0;
      sop      <= 1'b0;
      phase    <= '0;
    end else if (load) begin
      data_vld <= 1'b0;
    end else if (en) begin
      data_out <= w_cur_s[0];
      data_vld <= 1'b1;
      sop      <= (w_cur_cnt == '0);
      phase    <= w_cur_cnt;
    end else begin
      data_vld <= 1'b0;
      sop      <= 1'b0;
    end
  end

endmodule
`default_nettype wire
